// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command decoder: FSM states,
// command-byte layout and the fixed status/bad-address values.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_DRAIN
    } state_e;

    localparam int         CMD_WRITE_BIT = 7;
    localparam logic [6:0] STATUS_ADDR   = 7'h7F;
    localparam logic [7:0] BAD_ADDR_DATA = 8'hEE;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with a selectable
// reset value so an idle-high input does not glitch low out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so both flops
    // sample the pre-edge values and the chain really is two stages deep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// Byte-level command decoder behind an SPI slave: decodes one-byte reads and
// two-byte writes into a small register file and queues read-back data.
module spi_reg_bridge
    import spi_pkg::*;
#(
    parameter int         NUM_REGS  = 8,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                        system_clk,
    input  logic                        system_rst_n,
    input  logic                        spi_cs,
    input  logic                        data_ready,
    input  logic [7:0]                  received_data,
    output logic                        read_ack,
    output logic [7:0]                  data_to_send,
    input  logic [7:0]                  status_in,
    output logic [8*NUM_REGS-1:0]       reg_bus,
    output logic                        wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0] wr_addr,
    output logic [7:0]                  err_count
);

    localparam int         AW         = $clog2(NUM_REGS);
    localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);

    logic          cs_s;
    logic          data_ready_q;
    logic          new_byte;
    logic [1:0]    cs_valid_q;
    logic          armed_q;
    state_e        state_q;
    logic [6:0]    addr_q;
    logic          read_ack_q;
    logic          wr_strobe_q;
    logic [AW-1:0] wr_addr_q;
    logic [7:0]    err_q;
    logic [7:0]    data_to_send_q;
    logic [7:0]    regs_q [NUM_REGS];

    logic [6:0]    cmd_addr;
    logic [7:0]    rd_data;
    logic          rd_err;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk   (system_clk),
        .rst_n (system_rst_n),
        .d_i   (spi_cs),
        .q_o   (cs_s)
    );

    assign new_byte = data_ready & ~data_ready_q;
    assign cmd_addr = received_data[6:0];

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rd_data = BAD_ADDR_DATA;
        rd_err  = 1'b1;
        if (cmd_addr < NUM_REGS_A) begin
            rd_data = regs_q[cmd_addr[AW-1:0]];
            rd_err  = 1'b0;
        end else if (cmd_addr == STATUS_ADDR) begin
            rd_data = status_in;
            rd_err  = 1'b0;
        end
    end

    // cs_s only reflects the pin once both synchroniser flops have been
    // reloaded after reset; armed_q then demands a real CS-high before the
    // first frame so a reset in mid-frame realigns on the next frame start.
    always_ff @(posedge system_clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            data_ready_q   <= 1'b0;
            cs_valid_q     <= 2'b00;
            armed_q        <= 1'b0;
            state_q        <= ST_IDLE;
            addr_q         <= 7'd0;
            read_ack_q     <= 1'b0;
            wr_strobe_q    <= 1'b0;
            wr_addr_q      <= '0;
            err_q          <= 8'd0;
            data_to_send_q <= 8'h00;
            // NOTE: the register file is small and architecturally visible
            // with a defined reset value, so it is reset like any other flop.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            data_ready_q <= data_ready;
            cs_valid_q   <= {cs_valid_q[0], 1'b1};
            read_ack_q   <= 1'b0;
            wr_strobe_q  <= 1'b0;

            if (cs_s) begin
                if (cs_valid_q[1]) begin
                    armed_q <= 1'b1;
                end
                if (state_q == ST_WDATA) begin
                    err_q <= sat_inc(err_q);
                end
                state_q <= ST_IDLE;
            end else begin
                if (new_byte && state_q != ST_IDLE) begin
                    read_ack_q <= 1'b1;
                end

                case (state_q)
                    ST_IDLE: begin
                        if (armed_q) begin
                            state_q <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (new_byte) begin
                            addr_q <= cmd_addr;
                            if (received_data[CMD_WRITE_BIT]) begin
                                state_q <= ST_WDATA;
                            end else begin
                                state_q        <= ST_DRAIN;
                                data_to_send_q <= rd_data;
                                if (rd_err) begin
                                    err_q <= sat_inc(err_q);
                                end
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (new_byte) begin
                            state_q <= ST_DRAIN;
                            if (addr_q < NUM_REGS_A) begin
                                regs_q[addr_q[AW-1:0]] <= received_data;
                                wr_strobe_q            <= 1'b1;
                                wr_addr_q              <= addr_q[AW-1:0];
                            end else begin
                                err_q <= sat_inc(err_q);
                            end
                        end
                    end
                    ST_DRAIN: begin
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        reg_bus = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_bus[8*i +: 8] = regs_q[i];
        end
    end

    assign read_ack     = read_ack_q;
    assign wr_strobe    = wr_strobe_q;
    assign wr_addr      = wr_addr_q;
    assign err_count    = err_q;
    assign data_to_send = data_to_send_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: a table of whole frames with expected
// register/ack/error results, plus hand sequences for timing and reset cases.
module tb_spi_reg_bridge;

    logic        clk;
    logic        rst_n;
    logic        spi_cs;
    logic        data_ready;
    logic [7:0]  received_data;
    logic        read_ack;
    logic [7:0]  data_to_send;
    logic [7:0]  status_in;
    logic [63:0] reg_bus;
    logic        wr_strobe;
    logic [2:0]  wr_addr;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;
    int ack_total = 0;
    int stb_total = 0;

    spi_reg_bridge #(
        .NUM_REGS  (8),
        .RESET_VAL (8'h00)
    ) dut (
        .system_clk    (clk),
        .system_rst_n  (rst_n),
        .spi_cs        (spi_cs),
        .data_ready    (data_ready),
        .received_data (received_data),
        .read_ack      (read_ack),
        .data_to_send  (data_to_send),
        .status_in     (status_in),
        .reg_bus       (reg_bus),
        .wr_strobe     (wr_strobe),
        .wr_addr       (wr_addr),
        .err_count     (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (read_ack)  ack_total++;
        if (wr_strobe) stb_total++;
    end

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        int          nb;
        logic [7:0]  status;
        logic [7:0]  exp_dts;
        logic [7:0]  exp_err;
        logic [2:0]  exp_wr_addr;
        int          exp_acks;
        int          exp_stbs;
        logic [63:0] exp_bus;
    } frame_t;

    frame_t vec [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        data_ready    = 1'b1;
        received_data = b;
        repeat (3) @(negedge clk);
        data_ready = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    task automatic run_frame(input frame_t f);
        status_in = f.status;
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(f.b0);
        if (f.nb > 1) send_byte(f.b1);
        if (f.nb > 2) send_byte(f.b2);
        spi_cs = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int a0;
        int s0;

        //        b0     b1     b2    nb  status  dts    err    wa    acks stbs bus
        vec[0] = '{8'h83, 8'h5A, 8'h00, 2, 8'h00, 8'h00, 8'h00, 3'd3, 2, 1, 64'h00000000_5A000000};
        vec[1] = '{8'h03, 8'h00, 8'h00, 1, 8'h00, 8'h5A, 8'h00, 3'd3, 1, 0, 64'h00000000_5A000000};
        vec[2] = '{8'h7F, 8'h00, 8'h00, 1, 8'hC3, 8'hC3, 8'h00, 3'd3, 1, 0, 64'h00000000_5A000000};
        vec[3] = '{8'h90, 8'h11, 8'h00, 2, 8'h00, 8'hC3, 8'h01, 3'd3, 2, 0, 64'h00000000_5A000000};
        vec[4] = '{8'h10, 8'h00, 8'h00, 1, 8'h00, 8'hEE, 8'h02, 3'd3, 1, 0, 64'h00000000_5A000000};
        vec[5] = '{8'h81, 8'h22, 8'h33, 3, 8'h00, 8'hEE, 8'h02, 3'd1, 3, 1, 64'h00000000_5A002200};
        vec[6] = '{8'h85, 8'h00, 8'h00, 1, 8'h00, 8'hEE, 8'h03, 3'd1, 1, 0, 64'h00000000_5A002200};
        vec[7] = '{8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 8'h03, 3'd1, 1, 0, 64'h00000000_5A002200};

        rst_n         = 1'b0;
        spi_cs        = 1'b1;
        data_ready    = 1'b0;
        received_data = 8'h00;
        status_in     = 8'h00;
        repeat (3) @(negedge clk);
        check("reset read_ack",  64'(read_ack),     64'd0);
        check("reset wr_strobe", 64'(wr_strobe),    64'd0);
        check("reset err_count", 64'(err_count),    64'd0);
        check("reset dts",       64'(data_to_send), 64'h00);
        check("reset reg_bus",   reg_bus,           64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            a0 = ack_total;
            s0 = stb_total;
            run_frame(vec[i]);
            check($sformatf("v%0d reg_bus", i),      reg_bus,                vec[i].exp_bus);
            check($sformatf("v%0d data_to_send", i), 64'(data_to_send),      64'(vec[i].exp_dts));
            check($sformatf("v%0d err_count", i),    64'(err_count),         64'(vec[i].exp_err));
            check($sformatf("v%0d wr_addr", i),      64'(wr_addr),           64'(vec[i].exp_wr_addr));
            check($sformatf("v%0d acks", i),         64'(ack_total - a0),    64'(vec[i].exp_acks));
            check($sformatf("v%0d strobes", i),      64'(stb_total - s0),    64'(vec[i].exp_stbs));
        end

        // Read latency: data_to_send and read_ack appear together, one cycle after the byte.
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (5) @(negedge clk);
        data_ready    = 1'b1;
        received_data = 8'h03;
        @(negedge clk);
        check("rd timing ack",  64'(read_ack),     64'd1);
        check("rd timing dts",  64'(data_to_send), 64'h5A);
        @(negedge clk);
        check("rd ack one cycle", 64'(read_ack), 64'd0);
        data_ready = 1'b0;
        repeat (14) @(negedge clk);
        spi_cs = 1'b1;
        repeat (5) @(negedge clk);
        check("dts held after frame", 64'(data_to_send), 64'h5A);

        // Write latency: reg_bus, wr_strobe and read_ack in the same cycle.
        spi_cs = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(8'h84);
        data_ready    = 1'b1;
        received_data = 8'h99;
        @(negedge clk);
        check("wr timing ack",    64'(read_ack),       64'd1);
        check("wr timing strobe", 64'(wr_strobe),      64'd1);
        check("wr timing reg4",   64'(reg_bus[39:32]), 64'h99);
        data_ready = 1'b0;
        repeat (14) @(negedge clk);
        spi_cs = 1'b1;
        repeat (5) @(negedge clk);

        // data_ready left high across a frame boundary must not trigger a command.
        a0 = ack_total;
        spi_cs = 1'b0;
        repeat (5) @(negedge clk);
        data_ready    = 1'b1;
        received_data = 8'h02;
        repeat (3) @(negedge clk);
        spi_cs = 1'b1;
        repeat (5) @(negedge clk);
        spi_cs = 1'b0;
        repeat (10) @(negedge clk);
        check("stale byte acks", 64'(ack_total - a0), 64'd1);
        data_ready = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h82);
        send_byte(8'h77);
        spi_cs = 1'b1;
        repeat (5) @(negedge clk);
        check("post-stale write", reg_bus,          64'h00000099_5A772200);
        check("post-stale acks",  64'(ack_total - a0), 64'd3);
        check("post-stale err",   64'(err_count),   64'h03);

        // Reset in WDATA clears everything at once; frames only resume after CS cycles.
        spi_cs = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(8'h86);
        rst_n = 1'b0;
        #1;
        check("midrst reg_bus",   reg_bus,           64'd0);
        check("midrst err_count", 64'(err_count),    64'd0);
        check("midrst wr_addr",   64'(wr_addr),      64'd0);
        check("midrst dts",       64'(data_to_send), 64'h00);
        check("midrst read_ack",  64'(read_ack),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        a0 = ack_total;
        s0 = stb_total;
        send_byte(8'h86);
        send_byte(8'h44);
        check("unaligned acks",   64'(ack_total - a0), 64'd0);
        check("unaligned regbus", reg_bus,             64'd0);
        spi_cs = 1'b1;
        repeat (5) @(negedge clk);
        spi_cs = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(8'h86);
        send_byte(8'h44);
        spi_cs = 1'b1;
        repeat (5) @(negedge clk);
        check("realigned regbus",  reg_bus,             64'h00440000_00000000);
        check("realigned wr_addr", 64'(wr_addr),        64'd6);
        check("realigned strobes", 64'(stb_total - s0), 64'd1);
        check("realigned err",     64'(err_count),      64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
